// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Purpose  : MIPS write-back select, 32-entry register file with same-cycle
//            write-to-read bypass, and a committed-write counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            WB,
  input  logic [DATA_WIDTH-1:0] readData,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  regWrite_out,
  output logic [CNT_WIDTH-1:0]  commitCount
);

  localparam int                  c_NUM_REGS = 1 << ADDR_WIDTH;
  localparam int                  c_NUM_PORTS = 2;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
  logic [CNT_WIDTH-1:0]  r_commit_count;

  logic [DATA_WIDTH-1:0] w_write_data;
  logic                  w_reg_write;
  logic [ADDR_WIDTH-1:0] w_rd_addr [c_NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_rd_data [c_NUM_PORTS];

  assign w_write_data = WB[0] ? readData : ALUResult;
  assign w_reg_write  = WB[1] && (writeRegister != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_commit_count <= '0;
    end else if (w_reg_write) begin
      r_regs[writeRegister] <= w_write_data;
      r_commit_count        <= r_commit_count + c_CNT_ONE;
    end
  end

  assign w_rd_addr[0] = readReg1;
  assign w_rd_addr[1] = readReg2;

  // Index 0 is forced to zero here rather than trusting the array, so a
  // stale bypass can never leak a value onto r0.
  generate
    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_read_port
      always_comb begin
        w_rd_data[p] = r_regs[w_rd_addr[p]];
        if (w_rd_addr[p] == '0) begin
          w_rd_data[p] = '0;
        end else if (w_reg_write && (w_rd_addr[p] == writeRegister)) begin
          w_rd_data[p] = w_write_data;
        end
      end
    end
  endgenerate

  assign readData1    = w_rd_data[0];
  assign readData2    = w_rd_data[1];
  assign writeData    = w_write_data;
  assign regWrite_out = w_reg_write;
  assign commitCount  = r_commit_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [1:0]  WB;
  logic [31:0] readData;
  logic [31:0] ALUResult;
  logic [4:0]  writeRegister;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;

  logic [31:0] readData1, readData2, writeData;
  logic        regWrite_out;
  logic [31:0] commitCount;

  logic [31:0] c4_readData1, c4_readData2, c4_writeData;
  logic        c4_regWrite_out;
  logic [3:0]  c4_commitCount;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .WB(WB), .readData(readData),
    .ALUResult(ALUResult), .writeRegister(writeRegister),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .writeData(writeData),
    .regWrite_out(regWrite_out), .commitCount(commitCount)
  );

  // Narrow-counter instance shares all inputs; used for the wrap scenario.
  wb_regfile #(.CNT_WIDTH(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .WB(WB), .readData(readData),
    .ALUResult(ALUResult), .writeRegister(writeRegister),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(c4_readData1), .readData2(c4_readData2), .writeData(c4_writeData),
    .regWrite_out(c4_regWrite_out), .commitCount(c4_commitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WB = 2'b00;
    readData = '0;
    ALUResult = '0;
    writeRegister = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    readReg1 = 5'd1;
    readReg2 = 5'd2;
    tick();
    tick();
    checks++;
    if (commitCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_initial_count: got %0d expected 0", commitCount);
    end
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      WB = 2'b10;
      writeRegister = 5'(i);
      ALUResult = 32'h0101_0101 * i;
      tick();
    end
    idle();
    readReg1 = 5'd9;
    #1;
    checks++;
    if (readData1 !== 32'h0909_0909) begin
      errors++;
      $display("FAIL reset_prefill_r9: got %h expected 09090909", readData1);
    end
    checks++;
    if (commitCount !== 32'd31) begin
      errors++;
      $display("FAIL reset_prefill_count: got %0d expected 31", commitCount);
    end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      checks++;
      if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_clear idx %0d: got %h/%h expected 0/0", i, readData1, readData2);
      end
    end
    checks++;
    if (commitCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", commitCount);
    end
  endtask

  task automatic test_select_commit();
    WB = 2'b11;
    readData = 32'h0000_000F;
    ALUResult = 32'h0000_000B;
    writeRegister = 5'd31;
    #1;
    checks++;
    if (writeData !== 32'h0000_000F || regWrite_out !== 1'b1) begin
      errors++;
      $display("FAIL select_mem: got %h/%b expected 0000000f/1", writeData, regWrite_out);
    end
    tick();
    WB = 2'b10;
    writeRegister = 5'd30;
    #1;
    checks++;
    if (writeData !== 32'h0000_000B) begin
      errors++;
      $display("FAIL select_alu: got %h expected 0000000b", writeData);
    end
    tick();
    idle();
    readReg1 = 5'd31;
    readReg2 = 5'd30;
    #1;
    checks++;
    if (readData1 !== 32'h0000_000F || readData2 !== 32'h0000_000B) begin
      errors++;
      $display("FAIL commit_r31_r30: got %h/%h expected 0000000f/0000000b", readData1, readData2);
    end
    checks++;
    if (commitCount !== 32'd2) begin
      errors++;
      $display("FAIL commit_count: got %0d expected 2", commitCount);
    end
  endtask

  task automatic test_bypass();
    WB = 2'b10;
    ALUResult = 32'h1111_1111;
    writeRegister = 5'd5;
    tick();
    idle();
    readReg1 = 5'd5;
    readReg2 = 5'd5;
    #1;
    checks++;
    if (readData1 !== 32'h1111_1111) begin
      errors++;
      $display("FAIL bypass_old_value: got %h expected 11111111", readData1);
    end
    WB = 2'b10;
    ALUResult = 32'hDEAD_BEEF;
    writeRegister = 5'd5;
    #1;
    checks++;
    if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h/%h expected deadbeef/deadbeef", readData1, readData2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_after_edge: got %h/%h expected deadbeef/deadbeef", readData1, readData2);
    end
    checks++;
    if (commitCount !== 32'd4) begin
      errors++;
      $display("FAIL bypass_count: got %0d expected 4", commitCount);
    end
  endtask

  task automatic test_reg_zero();
    WB = 2'b11;
    writeRegister = 5'd0;
    readData = 32'hFFFF_FFFF;
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    #1;
    checks++;
    if (readData1 !== 32'd0 || regWrite_out !== 1'b0 || writeData !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_same_cycle: got rd1=%h we=%b wd=%h expected 0/0/ffffffff",
               readData1, regWrite_out, writeData);
    end
    tick();
    idle();
    #1;
    checks++;
    if (readData2 !== 32'd0 || commitCount !== 32'd4) begin
      errors++;
      $display("FAIL zero_after_edge: got rd2=%h cnt=%0d expected 0/4", readData2, commitCount);
    end
  endtask

  task automatic test_no_write();
    WB = 2'b10;
    ALUResult = 32'h0000_0077;
    writeRegister = 5'd7;
    tick();
    WB = 2'b01;
    readData = 32'h0000_AAAA;
    readReg1 = 5'd7;
    #1;
    checks++;
    if (regWrite_out !== 1'b0 || readData1 !== 32'h0000_0077) begin
      errors++;
      $display("FAIL nowrite_same_cycle: got we=%b rd1=%h expected 0/00000077", regWrite_out, readData1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (readData1 !== 32'h0000_0077 || commitCount !== 32'd5) begin
      errors++;
      $display("FAIL nowrite_after_edge: got rd1=%h cnt=%0d expected 00000077/5", readData1, commitCount);
    end
  endtask

  task automatic test_reset_collision();
    rst_n = 1'b0;
    WB = 2'b10;
    writeRegister = 5'd8;
    ALUResult = 32'h0000_1234;
    readReg1 = 5'd8;
    #1;
    checks++;
    if (writeData !== 32'h0000_1234 || regWrite_out !== 1'b1) begin
      errors++;
      $display("FAIL collision_comb_in_reset: got %h/%b expected 00001234/1", writeData, regWrite_out);
    end
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (readData1 !== 32'd0 || commitCount !== 32'd0) begin
      errors++;
      $display("FAIL collision_dropped: got rd1=%h cnt=%0d expected 0/0", readData1, commitCount);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      WB = 2'b10;
      writeRegister = 5'(10 + i);
      ALUResult = 32'hA000_0000 + i;
      tick();
    end
    idle();
    readReg1 = 5'd10;
    readReg2 = 5'd12;
    #1;
    checks++;
    if (readData1 !== 32'hA000_0000 || readData2 !== 32'hA000_0002) begin
      errors++;
      $display("FAIL b2b_r10_r12: got %h/%h expected a0000000/a0000002", readData1, readData2);
    end
    readReg1 = 5'd11;
    #1;
    checks++;
    if (readData1 !== 32'hA000_0001 || commitCount !== 32'd3) begin
      errors++;
      $display("FAIL b2b_r11_count: got %h cnt=%0d expected a0000001/3", readData1, commitCount);
    end
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    checks++;
    if (c4_commitCount !== 4'd0) begin
      errors++;
      $display("FAIL wrap_start: got %0d expected 0", c4_commitCount);
    end
    for (int i = 1; i <= 17; i++) begin
      WB = 2'b10;
      writeRegister = 5'd3;
      ALUResult = 32'(i);
      tick();
      if (i == 15) begin
        checks++;
        if (c4_commitCount !== 4'd15) begin
          errors++;
          $display("FAIL wrap_at_15: got %0d expected 15", c4_commitCount);
        end
      end
    end
    idle();
    readReg1 = 5'd3;
    #1;
    checks++;
    if (c4_commitCount !== 4'd1) begin
      errors++;
      $display("FAIL wrap_after_17: got %0d expected 1", c4_commitCount);
    end
    checks++;
    if (commitCount !== 32'd17 || c4_readData1 !== 32'd17) begin
      errors++;
      $display("FAIL wrap_wide_count_r3: got cnt=%0d r3=%0d expected 17/17", commitCount, c4_readData1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    readReg1 = '0;
    readReg2 = '0;
    idle();
    test_reset();
    test_select_commit();
    test_bypass();
    test_reg_zero();
    test_no_write();
    test_reset_collision();
    test_back_to_back();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs (control bits, memory read data, ALU result, destination register), selects the write-back value, and commits it to a 32-entry register file. It also serves the two combinational read ports used by the ID stage, with same-cycle write-to-read bypass, and keeps a committed-write counter for debug and performance monitoring.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data width
- ADDR_WIDTH, 5, register index width; the file has 2^ADDR_WIDTH entries
- CNT_WIDTH, 32, width of the commit counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- WB  input  2  write-back control from MEM/WB; WB[1]=RegWrite, WB[0]=MemtoReg
- readData  input  DATA_WIDTH  data-memory read value from MEM/WB
- ALUResult  input  DATA_WIDTH  ALU result from MEM/WB
- writeRegister  input  ADDR_WIDTH  destination register index from MEM/WB
- readReg1, readReg2  input  ADDR_WIDTH  ID-stage source register indices
- readData1, readData2  output  DATA_WIDTH  source operand values (combinational)
- writeData  output  DATA_WIDTH  selected write-back value, used by EX forwarding (combinational)
- regWrite_out  output  1  effective write enable: WB[1] && writeRegister!=0 (combinational)
- commitCount  output  CNT_WIDTH  number of committed register writes (registered)

## Operation
- Write-back select: writeData = WB[0] ? readData : ALUResult. The select is evaluated every cycle, regardless of WB[1].
- Commit: on a rising edge with rst_n=1 and regWrite_out=1, regs[writeRegister] <= writeData.
- Register 0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - A read of index 0 always returns 0.
  - Index 0 is never bypassed.
- Read ports are asynchronous: readDataN = regs[readRegN] for N = 1 or 2.
- Bypass: if regWrite_out=1 and readRegN==writeRegister, readDataN = writeData in that same cycle. This makes a write and a read of the same register in the same cycle return the new value, so the ID stage needs no split-cycle clocking.
- Both read ports may address the same register, and both bypass independently.
- Commit counter:
  - Increments by 1 on each rising edge where rst_n=1 and regWrite_out=1.
  - Writes to index 0 are not counted.
  - Wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- Reset (rst_n=0 at a rising edge):
  - All registers are cleared to 0 and commitCount is cleared to 0.
  - Reset wins over a simultaneous commit; that write is lost and not counted.
- X on WB[1] is treated as no write by the verification checkers, so the bench must drive known values.

## Timing
- Latency from MEM/WB output to architectural state is 1 edge. The value is visible through the array on the cycle after the edge, and through the bypass in the cycle before it.
- readData1, readData2, writeData and regWrite_out are purely combinational from inputs and state, with no cycle latency.
- commitCount is registered and reflects a commit on the cycle after its edge.
- Reset value of every output: readDataN = 0 (all registers zero, assuming no bypass), commitCount = 0. writeData and regWrite_out follow their inputs even while rst_n=0, but no state is updated.
- Reset mid-operation: any write presented at the reset edge is dropped. Normal commits resume on the first edge with rst_n=1.
- No handshake: the block accepts one write-back per cycle unconditionally, and there is no stall input.

## Test plan
- Reset: hold rst_n=0 for 2 edges after writing regs 1..31 with nonzero values, then release. Required: readData1/2 = 0 for every index, and commitCount = 0.
- Select and commit: WB=2'b11, readData=0x0000000F, ALUResult=0x0000000B, writeRegister=31, one edge. Required: regs[31]=0x0F. Then WB=2'b10, same data, writeRegister=30. Required: regs[30]=0x0B. commitCount = 2.
- Bypass: with regs[5]=0x11111111 already committed, in one cycle drive WB=2'b10, ALUResult=0xDEADBEEF, writeRegister=5, readReg1=readReg2=5. Required: readData1=readData2=0xDEADBEEF before the edge and after it.
- Register zero: WB=2'b11, writeRegister=0, readData=0xFFFFFFFF, readReg1=0. Required: readData1=0, regWrite_out=0, and commitCount unchanged after the edge.
- No-write and reset collision:
  - WB=2'b01 with writeRegister=7. Required: regs[7] unchanged and no count.
  - WB=2'b10, writeRegister=8, ALUResult=0x1234 with rst_n=0 on the same edge. Required: regs[8]=0 and commitCount=0.
- Counter wrap: use CNT_WIDTH=4 and perform 17 writes to register 3. Required: commitCount = 1 after the 17th edge.
